// File: rtl/traffic_ctrl_param.sv
// Two-approach traffic-light controller: one phase FSM, all-red clearance,
// demand-driven left turns, night flashing yellow and saturating BCD countdowns.
module traffic_ctrl_param #(
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned T_GREEN_A = 40,
    parameter int unsigned T_LEFT_A  = 15,
    parameter int unsigned T_GREEN_B = 30,
    parameter int unsigned T_LEFT_B  = 15,
    parameter int unsigned T_YELLOW  = 5,
    parameter int unsigned T_ALLRED  = 2,
    parameter int unsigned DIGITS    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  night,
    input  logic                  left_req_a,
    input  logic                  left_req_b,
    output logic [3:0]            lampa,
    output logic [3:0]            lampb,
    output logic [4*DIGITS-1:0]   acount,
    output logic [4*DIGITS-1:0]   bcount
);

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam int unsigned SUM_A   = T_GREEN_A + T_LEFT_A + 2 * T_YELLOW + T_ALLRED;
    localparam int unsigned SUM_B   = T_GREEN_B + T_LEFT_B + 2 * T_YELLOW + T_ALLRED;
    localparam int unsigned MAX_SUM = (SUM_A > SUM_B) ? SUM_A : SUM_B;
    localparam int unsigned CW      = $clog2(MAX_SUM + 1);
    localparam int unsigned PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam longint unsigned BCD_MAX = pow10(DIGITS) - 64'd1;
    localparam bit HAS_CLR = (T_ALLRED != 0);

    localparam logic [CW-1:0] TGA = CW'(T_GREEN_A);
    localparam logic [CW-1:0] TLA = CW'(T_LEFT_A);
    localparam logic [CW-1:0] TGB = CW'(T_GREEN_B);
    localparam logic [CW-1:0] TLB = CW'(T_LEFT_B);
    localparam logic [CW-1:0] TY  = CW'(T_YELLOW);
    localparam logic [CW-1:0] TAR = CW'(T_ALLRED);

    localparam logic [3:0] L_RED  = 4'b1000;
    localparam logic [3:0] L_YEL  = 4'b0100;
    localparam logic [3:0] L_GRN  = 4'b0010;
    localparam logic [3:0] L_LEFT = 4'b0001;
    localparam logic [3:0] L_DARK = 4'b0000;

    typedef enum logic [3:0] {
        HOLD, A_GO, A_Y1, A_LEFT, A_Y2, CLR_A,
        B_GO, B_Y1, B_LEFT, B_Y2, CLR_B, NIGHT
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   rem, rem_n;
    logic            blink, blink_n;
    logic            left_a, left_a_n, left_b, left_b_n;
    logic [PW-1:0]   presc;
    logic            tick_c;
    logic [3:0]      lampa_n, lampb_n;
    logic [CW-1:0]   acnt_n, bcnt_n;
    logic [CW-1:0]   extra_a, extra_b;

    function automatic state_t next_phase(input state_t s, input logic la, input logic lb);
        state_t r;
        r = HOLD;
        case (s)
            HOLD:    r = A_GO;
            A_GO:    r = A_Y1;
            A_Y1:    r = la ? A_LEFT : (HAS_CLR ? CLR_A : B_GO);
            A_LEFT:  r = A_Y2;
            A_Y2:    r = HAS_CLR ? CLR_A : B_GO;
            CLR_A:   r = B_GO;
            B_GO:    r = B_Y1;
            B_Y1:    r = lb ? B_LEFT : (HAS_CLR ? CLR_B : A_GO);
            B_LEFT:  r = B_Y2;
            B_Y2:    r = HAS_CLR ? CLR_B : A_GO;
            CLR_B:   r = A_GO;
            NIGHT:   r = HAS_CLR ? CLR_B : A_GO;
            default: r = HOLD;
        endcase
        return r;
    endfunction

    function automatic logic [CW-1:0] phase_len(input state_t s);
        logic [CW-1:0] r;
        r = '0;
        case (s)
            A_GO:                    r = TGA;
            B_GO:                    r = TGB;
            A_LEFT:                  r = TLA;
            B_LEFT:                  r = TLB;
            A_Y1, A_Y2, B_Y1, B_Y2:  r = TY;
            CLR_A, CLR_B:            r = TAR;
            default:                 r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input logic [CW-1:0] v);
        logic [4*DIGITS-1:0] r;
        int unsigned         x;
        r = '0;
        x = 32'(v);
        if (64'(x) > BCD_MAX) begin
            r = {DIGITS{4'h9}};
        end else begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                r[4*i +: 4] = 4'(x % 32'd10);
                x = x / 32'd10;
            end
        end
        return r;
    endfunction

    assign tick_c = en && (presc == PW'(TICK_DIV - 1));

    // Tick prescaler, held clear while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                presc <= '0;
        else if (!en || tick_c) presc <= '0;
        else                    presc <= presc + PW'(1);
    end

    // Phase sequencing: enable beats night, night beats the normal sequence
    always_comb begin
        state_n  = state;
        rem_n    = rem;
        blink_n  = blink;
        left_a_n = left_a;
        left_b_n = left_b;
        if (!en) begin
            state_n = HOLD;
            rem_n   = '0;
            blink_n = 1'b0;
        end else if (tick_c) begin
            if (night) begin
                state_n = NIGHT;
                rem_n   = '0;
                blink_n = (state == NIGHT) ? ~blink : 1'b1;
            end else if (state == HOLD || state == NIGHT || rem <= CW'(1)) begin
                state_n = next_phase(state, left_a, left_b);
                rem_n   = phase_len(state_n);
                blink_n = 1'b0;
                if (state_n == A_GO) left_a_n = left_req_a;
                if (state_n == B_GO) left_b_n = left_req_b;
            end else begin
                rem_n = rem - CW'(1);
            end
        end
    end

    // Lamps and countdowns for the upcoming state; red side adds phases before its green
    always_comb begin
        lampa_n = L_RED;
        lampb_n = L_RED;
        acnt_n  = '0;
        bcnt_n  = '0;
        extra_a = left_a_n ? (TLA + TY) : '0;
        extra_b = left_b_n ? (TLB + TY) : '0;
        case (state_n)
            A_GO:   begin lampa_n = L_GRN;  acnt_n = rem_n; bcnt_n = rem_n + TY + extra_a + TAR; end
            A_Y1:   begin lampa_n = L_YEL;  acnt_n = rem_n; bcnt_n = rem_n + extra_a + TAR; end
            A_LEFT: begin lampa_n = L_LEFT; acnt_n = rem_n; bcnt_n = rem_n + TY + TAR; end
            A_Y2:   begin lampa_n = L_YEL;  acnt_n = rem_n; bcnt_n = rem_n + TAR; end
            B_GO:   begin lampb_n = L_GRN;  bcnt_n = rem_n; acnt_n = rem_n + TY + extra_b + TAR; end
            B_Y1:   begin lampb_n = L_YEL;  bcnt_n = rem_n; acnt_n = rem_n + extra_b + TAR; end
            B_LEFT: begin lampb_n = L_LEFT; bcnt_n = rem_n; acnt_n = rem_n + TY + TAR; end
            B_Y2:   begin lampb_n = L_YEL;  bcnt_n = rem_n; acnt_n = rem_n + TAR; end
            CLR_A, CLR_B: begin acnt_n = rem_n; bcnt_n = rem_n; end
            NIGHT: begin
                lampa_n = blink_n ? L_YEL : L_DARK;
                lampb_n = blink_n ? L_YEL : L_DARK;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= HOLD;
            rem    <= '0;
            blink  <= 1'b0;
            left_a <= 1'b0;
            left_b <= 1'b0;
            lampa  <= L_RED;
            lampb  <= L_RED;
            acount <= '0;
            bcount <= '0;
        end else begin
            state  <= state_n;
            rem    <= rem_n;
            blink  <= blink_n;
            left_a <= left_a_n;
            left_b <= left_b_n;
            lampa  <= lampa_n;
            lampb  <= lampb_n;
            acount <= to_bcd(acnt_n);
            bcount <= to_bcd(bcnt_n);
        end
    end

endmodule

// File: doc/traffic_ctrl_param.md
# traffic_ctrl_param

Parametrised two-direction traffic-light controller. A single phase FSM drives both approaches, which rules out conflicting greens. It replaces fixed-duration, free-running per-direction counters with:
- configurable phase times,
- an all-red clearance interval,
- demand-driven left-turn phases,
- a night flashing-yellow mode,
- BCD countdowns of configurable digit count.

It sits between the board clock and the lamp drivers and 7-segment digit decoders.

## Interface
Parameters:
- TICK_DIV, 1: clk cycles per countdown tick (1 = every clk); must be ≥1.
- T_GREEN_A, 40: A straight-green ticks (≥1).
- T_LEFT_A, 15: A left-turn ticks (≥1).
- T_GREEN_B, 30: B straight-green ticks (≥1).
- T_LEFT_B, 15: B left-turn ticks (≥1).
- T_YELLOW, 5: each yellow phase, ticks (≥1).
- T_ALLRED, 2: clearance ticks after each direction (0 = phase skipped).
- DIGITS, 2: BCD digits per countdown output.

Ports:
- clk, input, 1: system clock; single clock domain.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: run enable; low forces the HOLD state.
- night, input, 1: night flashing-yellow mode request.
- left_req_a, input, 1: A left-turn demand, sampled on entry to A_GO.
- left_req_b, input, 1: B left-turn demand, sampled on entry to B_GO.
- lampa, output, 4: A lamps, one-hot {red, yellow, green, left}: 1000/0100/0010/0001, 0000 = dark.
- lampb, output, 4: B lamps, same encoding.
- acount, output, 4*DIGITS: A ticks remaining in current lamp colour, BCD, digit 0 in [3:0].
- bcount, output, 4*DIGITS: B ticks remaining in current lamp colour, BCD.

## Operation
- **Prescaler:** counts 0..TICK_DIV-1 while en=1 and emits an internal one-cycle tick on wrap. It is cleared while en=0.
- **States:** HOLD, A_GO, A_Y1, A_LEFT, A_Y2, CLR_A, B_GO, B_Y1, B_LEFT, B_Y2, CLR_B, NIGHT.
- **Lamps per state:**
  - HOLD: both 1000.
  - A_GO: A=0010, B=1000.
  - A_Y1 and A_Y2: A=0100, B=1000.
  - A_LEFT: A=0001, B=1000.
  - CLR_A and CLR_B: both 1000.
  - B phases mirror A phases.
  - NIGHT: both 0100 and 0000, alternating each tick.
- **Cycle order:** HOLD → A_GO → A_Y1 → [A_LEFT → A_Y2] → CLR_A → B_GO → B_Y1 → [B_LEFT → B_Y2] → CLR_B → A_GO.
  - The bracketed steps are skipped when the latched left_req is 0: A_Y1 goes directly to CLR_A.
  - CLR_x is skipped when T_ALLRED=0.
- **Phase length:** each phase lasts exactly its T ticks. A binary remaining-counter loads T on entry, decrements each tick, and the state advances on the tick where it equals 1.
- **Countdowns:**
  - Green, left or yellow direction: remaining ticks of the current phase.
  - Red direction: current phase remaining plus the durations of every phase before its own green. Those durations use the latched left demand of the other direction and include CLR.
  - The binary value is converted to BCD and saturates at 10^DIGITS−1.
  - HOLD and NIGHT: both counts 0.
- **Night mode:**
  - The night=1 level is evaluated on each tick; the first tick with night=1 enters NIGHT from any state, showing yellow-on.
  - The first tick with night=0 enters CLR_B, or A_GO when T_ALLRED=0.
- **Enable:** en=0 forces HOLD synchronously on the next clk edge, overriding night. The first tick after en rises enters A_GO, or NIGHT if night=1.
- **Priority:** rst > en=0 > night > sequence.

## Timing
- **Reset:** while rst=1 and after it:
  - State is HOLD.
  - lampa and lampb are 1000.
  - acount and bcount are 0.
  - The prescaler and latched left demands are 0.
- **Output latency:** all outputs are registered. Lamps and counts change on the clk edge where the tick is high, one edge after the prescaler wrap condition.
- **Tick period:** with TICK_DIV=1, a tick occurs every clk while en=1, so the first A_GO occurs on the first clk edge with en=1.
- **Demand sampling:** left_req_x is sampled only on the tick entering x_GO; later changes take effect in the next cycle.
- **Reset mid-phase:** the phase is abandoned immediately with no yellow. Restart is always at A_GO.
- **Width:** internal counters are sized for the maximum red sum: T_GREEN+T_YELLOW·2+T_LEFT+T_ALLRED of the larger direction.

## Test plan
- **Full cycle, defaults, both left demands high:**
  - First tick after en → A_GO with acount=40, bcount=67.
  - Full cycle is 124 ticks.
  - CLR_A shows both counts 2 then 1.
  - B_GO shows bcount=30, acount=57.
- **left_req_a=0 at A_GO entry:**
  - bcount=47 at entry.
  - A_Y1 (acount 5..1) goes to CLR_A with no 0001 lamp.
  - A_GO→B_GO spans 47 ticks.
- **Night mode:**
  - night=1 mid A_LEFT → next tick both 0100, then 0000, alternating; counts 0.
  - night=0 → CLR_B for 2 ticks, then A_GO with acount=40.
- **Enable low mid-phase:** en=0 during B_Y1 → next edge both 1000, counts 0; en=1 → A_GO on the first tick.
- **Reset mid-phase:** rst pulse mid A_GO with TICK_DIV=4 → outputs go to reset values asynchronously; first A_GO 4 clk after rst falls.
- **Saturation:** DIGITS=1 → at A_GO entry bcount=9 (saturated) and acount=9; acount holds 9 until the remaining count ≤9.
